ysyx_23060124_regfile_sb: RTL and testbench

Parametrised integer register file with N read ports, M prioritised forwarding sources, a write-through commit port and a per-register busy scoreboard. It sits between decode/issue and the execute/writeback stages. It supplies operands with a per-port "not ready" flag, so the issue stage can stall on RAW hazards instead of relying on full forwarding coverage. Unlike the previous single-issue file, the register array and scoreboard are cleared by reset. The block also accepts issue handshakes and supports a pipeline flush.

---
 rtl/ysyx_23060124_rf_pkg.sv | 14 +
 rtl/ysyx_23060124_rf_scoreboard.sv | 76 +++++++
 rtl/ysyx_23060124_regfile_sb.sv | 100 ++++++++++
 tb/tb_ysyx_23060124_regfile_sb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060124_rf_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060124_rf_pkg
// Shared constants for the register file with scoreboard:
//   XLEN_DEF  - default data width
//   NREG_DEF  - default number of architectural registers
//   ZERO_REG  - index of the hardwired zero register
// ----------------------------------------------------------------------------
package ysyx_23060124_rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 16;
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/ysyx_23060124_rf_scoreboard.sv
// ----------------------------------------------------------------------------
// ysyx_23060124_rf_scoreboard
// Per-register busy tracking for in-flight destinations.
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-low reset
//   wr_en, wr_addr     - commit port; clears the committed register's bit
//   iss_valid, iss_rd  - issue request carrying a destination register
//   iss_ready          - issue accepted this cycle
//   flush              - drop every in-flight destination
//   busy               - current busy vector (bit 0 always 0)
//   busy_cnt           - registered population count of busy
// ----------------------------------------------------------------------------
module ysyx_23060124_rf_scoreboard
    import ysyx_23060124_rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          flush,
    output logic          iss_ready,
    output logic [NREG-1:0] busy,
    output logic [AW:0]   busy_cnt
);

    logic            iss_fire;
    logic            wr_live;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_next;

    assign wr_live = wr_en && (wr_addr != AW'(ZERO_REG));

    // A commit to the requested destination in the same cycle frees it, so
    // retire and reissue of one register can happen back to back.
    assign iss_ready = !flush &&
                       ((iss_rd == AW'(ZERO_REG)) || !busy[iss_rd] ||
                        (wr_en && (wr_addr == iss_rd)));

    assign iss_fire = iss_valid && iss_ready;

    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_live)
                busy_next[wr_addr] = 1'b0;
            // Applied after the clear so a same-cycle set wins.
            if (iss_fire && (iss_rd != AW'(ZERO_REG)))
                busy_next[iss_rd] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++)
            cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/ysyx_23060124_regfile_sb.sv
// ----------------------------------------------------------------------------
// ysyx_23060124_regfile_sb
// Integer register file with NRD combinational read ports, NFWD prioritised
// forwarding sources, a write-through commit port and a busy scoreboard.
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   rd_addr/rd_data/rd_busy- read ports, port k in slice k
//   fwd_valid/addr/data    - forwarding sources, index 0 has priority
//   wr_en/wr_addr/wr_data  - commit write (also bypassed to the reads)
//   iss_valid/iss_rd/ready - issue handshake for destination tracking
//   flush                  - clear all in-flight destinations
//   busy_cnt               - number of registers currently busy
// ----------------------------------------------------------------------------
module ysyx_23060124_regfile_sb
    import ysyx_23060124_rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NFWD = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_ready,
    input  logic                 flush,
    output logic [AW:0]          busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wr_en && (wr_addr != AW'(ZERO_REG))) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Sources are layered from lowest to highest priority so the last
    // assignment that matches is the one that wins.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin : g_port
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            bsy;
            addr = rd_addr[k*AW +: AW];
            data = regs[addr];
            bsy  = busy[addr];
            if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
                bsy  = 1'b0;
            end
            for (int j = NFWD - 1; j >= 0; j--) begin
                if (fwd_valid[j] && (fwd_addr[j*AW +: AW] == addr)) begin
                    data = fwd_data[j*XLEN +: XLEN];
                    bsy  = 1'b0;
                end
            end
            if (addr == AW'(ZERO_REG)) begin
                data = '0;
                bsy  = 1'b0;
            end
            rd_data[k*XLEN +: XLEN] = data;
            rd_busy[k]              = bsy;
        end
    end

    ysyx_23060124_rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .iss_ready (iss_ready),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_ysyx_23060124_regfile_sb.sv
module tb_ysyx_23060124_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int NRD  = 2;
    localparam int NFWD = 2;
    localparam int AW   = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NRD*AW-1:0]    rd_addr = '0;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NFWD-1:0]      fwd_valid = '0;
    logic [NFWD*AW-1:0]   fwd_addr = '0;
    logic [NFWD*XLEN-1:0] fwd_data = '0;
    logic                 wr_en = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic [XLEN-1:0]      wr_data = '0;
    logic                 iss_valid = 1'b0;
    logic [AW-1:0]        iss_rd = '0;
    logic                 iss_ready;
    logic                 flush = 1'b0;
    logic [AW:0]          busy_cnt;

    int checks = 0;
    int errors = 0;

    ysyx_23060124_regfile_sb #(
        .XLEN (XLEN), .NREG (NREG), .NRD (NRD), .NFWD (NFWD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    function automatic bit exp_ready();
        if (flush) return 1'b0;
        if (iss_rd == 0) return 1'b1;
        if (wr_en && wr_addr == iss_rd) return 1'b1;
        return !m_busy[iss_rd];
    endfunction

    // Returns {busy, data} for a read of register a.
    function automatic logic [XLEN:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        for (int j = 0; j < NFWD; j++)
            if (fwd_valid[j] && fwd_addr[j*AW +: AW] == a)
                return {1'b0, fwd_data[j*XLEN +: XLEN]};
        if (wr_en && wr_addr == a) return {1'b0, wr_data};
        return {m_busy[a], m_regs[a]};
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += m_busy[i];
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            bit fire;
            fire = iss_valid && exp_ready();
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
                if (fire && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle compare against the model.
    always @(negedge clock) begin
        logic [XLEN:0] e;
        for (int k = 0; k < NRD; k++) begin
            e = exp_read(rd_addr[k*AW +: AW]);
            chk($sformatf("model_rd_data%0d", k), 64'(rd_data[k*XLEN +: XLEN]), 64'(e[XLEN-1:0]));
            chk($sformatf("model_rd_busy%0d", k), 64'(rd_busy[k]), 64'(e[XLEN]));
        end
        chk("model_iss_ready", 64'(iss_ready), 64'(exp_ready()));
        chk("model_busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_fwd(input int j, input bit v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        fwd_valid[j] = v;
        fwd_addr[j*AW +: AW] = a;
        fwd_data[j*XLEN +: XLEN] = d;
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("reset_iss_ready", 64'(iss_ready), 64'd1);
        chk("reset_rd_busy", 64'(rd_busy), 64'd0);
        tick();
        reset = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            set_rd(0, AW'(r));
            set_rd(1, AW'(NREG - 1 - r));
            tick();
            chk("reset_read_data", 64'(rd_data), 64'd0);
            chk("reset_read_busy", 64'(rd_busy), 64'd0);
        end

        // Issue x5, forward, commit
        iss_valid = 1'b1; iss_rd = 4'd5;
        chk("issue5_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;
        set_rd(0, 4'd5); set_rd(1, 4'd0);
        #1;
        chk("x5_busy", 64'(rd_busy[0]), 64'd1);
        chk("x5_busy_cnt", 64'(busy_cnt), 64'd1);
        set_fwd(1, 1'b1, 4'd5, 32'hAB);
        #1;
        chk("x5_fwd1_data", 64'(rd_data[31:0]), 64'hAB);
        chk("x5_fwd1_busy", 64'(rd_busy[0]), 64'd0);
        set_fwd(1, 1'b0, 4'd0, 32'h0);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hCD;
        #1;
        chk("x5_bypass_data", 64'(rd_data[31:0]), 64'hCD);
        chk("x5_bypass_busy", 64'(rd_busy[0]), 64'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("x5_commit_cnt", 64'(busy_cnt), 64'd0);
        chk("x5_array_data", 64'(rd_data[31:0]), 64'hCD);
        tick();

        // Forward priority on x3
        set_rd(1, 4'd3);
        set_fwd(0, 1'b1, 4'd3, 32'h11);
        set_fwd(1, 1'b1, 4'd3, 32'h22);
        #1;
        chk("fwd_prio_both", 64'(rd_data[63:32]), 64'h11);
        tick();
        fwd_valid[0] = 1'b0;
        #1;
        chk("fwd_prio_only1", 64'(rd_data[63:32]), 64'h22);
        tick();
        fwd_valid = '0;

        // WAW stall on x7, same-cycle retire/reissue
        iss_valid = 1'b1; iss_rd = 4'd7;
        tick();
        #1;
        chk("x7_waw_stall", 64'(iss_ready), 64'd0);
        tick();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
        #1;
        chk("x7_reissue_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0; wr_en = 1'b0;
        set_rd(0, 4'd7);
        #1;
        chk("x7_still_busy", 64'(rd_busy[0]), 64'd1);
        chk("x7_cnt", 64'(busy_cnt), 64'd1);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h78;
        tick();
        wr_en = 1'b0;
        #1;
        chk("x7_retired_cnt", 64'(busy_cnt), 64'd0);
        chk("x7_data", 64'(rd_data[31:0]), 64'h78);

        // Issue x2,x4,x6 then flush
        iss_valid = 1'b1;
        iss_rd = 4'd2; tick();
        iss_rd = 4'd4; tick();
        iss_rd = 4'd6; tick();
        iss_valid = 1'b0;
        #1;
        chk("three_busy_cnt", 64'(busy_cnt), 64'd3);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 4'd8;
        #1;
        chk("flush_not_ready", 64'(iss_ready), 64'd0);
        tick();
        flush = 1'b0; iss_valid = 1'b0;
        set_rd(0, 4'd8); set_rd(1, 4'd2);
        #1;
        chk("flush_cnt", 64'(busy_cnt), 64'd0);
        chk("flush_x8_busy", 64'(rd_busy[0]), 64'd0);
        chk("flush_x2_busy", 64'(rd_busy[1]), 64'd0);

        // Writes/issues to x0
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_rd = 4'd0;
        set_rd(0, 4'd0);
        #1;
        chk("x0_bypass_data", 64'(rd_data[31:0]), 64'd0);
        chk("x0_issue_ready", 64'(iss_ready), 64'd1);
        tick();
        wr_en = 1'b0; iss_valid = 1'b0;
        #1;
        chk("x0_data", 64'(rd_data[31:0]), 64'd0);
        chk("x0_cnt", 64'(busy_cnt), 64'd0);

        // Build state, then asynchronous reset mid-cycle
        iss_valid = 1'b1; iss_rd = 4'd9; tick();
        iss_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 32'h1234; tick();
        wr_en = 1'b0;
        set_rd(0, 4'd10); set_rd(1, 4'd9);
        #1;
        chk("pre_reset_data", 64'(rd_data[31:0]), 64'h1234);
        chk("pre_reset_busy9", 64'(rd_busy[1]), 64'd1);
        chk("pre_reset_cnt", 64'(busy_cnt), 64'd1);
        iss_valid = 1'b1; iss_rd = 4'd9;
        #1;
        chk("pre_reset_stall9", 64'(iss_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("async_reset_data", 64'(rd_data), 64'd0);
        chk("async_reset_busy", 64'(rd_busy), 64'd0);
        chk("async_reset_cnt", 64'(busy_cnt), 64'd0);
        chk("async_reset_ready", 64'(iss_ready), 64'd1);
        iss_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
